// File: rtl/mem_port_arbiter.sv
// Single-port data memory arbiter: fetch (read-only) vs memory stage (rd/wr).
// Optional I-port fairness counter is enabled by defining MEM_PORT_ARBITER_FAIR_EN.
module mem_port_arbiter #(
    parameter int LATENCY    = 1,
    parameter int FAIR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_ready,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ready,
    output logic [15:0] d_rdata,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    output logic        stall_fetch,
    output logic        stall_mem
);

    if (LATENCY < 1 || LATENCY > 15 || FAIR_LIMIT < 1 || FAIR_LIMIT > 15) begin : g_bad_param
        $error("mem_port_arbiter: LATENCY/FAIR_LIMIT out of range 1..15");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        own_d_q, own_d_d;
    logic        en_q, en_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        i_ready_q, i_ready_d;
    logic        d_ready_q, d_ready_d;
    logic [15:0] i_rdata_q, i_rdata_d;
    logic [15:0] d_rdata_q, d_rdata_d;
    logic        grant_d;
    logic        grant_i;

`ifdef MEM_PORT_ARBITER_FAIR_EN
    localparam logic [3:0] FLIM = 4'(FAIR_LIMIT);

    logic [3:0] fair_q, fair_d;

    // I wins a tie once D has taken FAIR_LIMIT grants in a row while I waited
    assign grant_d = d_req & ~(i_req & (fair_q == FLIM));

    always_comb begin
        fair_d = fair_q;
        if (state_q == IDLE) begin
            if (grant_i) begin
                fair_d = 4'd0;
            end else if (grant_d && i_req && fair_q != FLIM) begin
                fair_d = fair_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fair_q <= 4'd0;
        end else begin
            fair_q <= fair_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    assign grant_i = i_req & ~grant_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        own_d_d   = own_d_q;
        en_d      = 1'b0;
        wr_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_d || grant_i) begin
                    state_d = ACCESS;
                    cnt_d   = LAT_M1;
                    own_d_d = grant_d;
                    en_d    = 1'b1;
                    wr_d    = grant_d & d_wr;
                    addr_d  = grant_d ? d_addr : i_addr;
                    if (grant_d && d_wr) begin
                        wdata_d = d_wdata;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d   = RESP;
                    i_ready_d = ~own_d_q;
                    d_ready_d = own_d_q;
                    if (!wr_q) begin
                        if (own_d_q) begin
                            d_rdata_d = mem_data_out;
                        end else begin
                            i_rdata_d = mem_data_out;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    en_d  = 1'b1;
                    wr_d  = wr_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            own_d_q   <= 1'b0;
            en_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            i_rdata_q <= 16'h0000;
            d_rdata_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            own_d_q   <= own_d_d;
            en_q      <= en_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_ready     = i_ready_q;
    assign d_ready     = d_ready_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign mem_enable  = en_q;
    assign mem_wr      = wr_q;
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign stall_fetch = i_req & ~i_ready_q;
    assign stall_mem   = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A has LATENCY=2,
// instance B has LATENCY=1 and FAIR_LIMIT=2; both share the request inputs.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;

    logic        a_i_ready, a_d_ready, a_mem_enable, a_mem_wr;
    logic [15:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_data_in, a_mem_data_out;
    logic        a_stall_fetch, a_stall_mem;
    logic        b_i_ready, b_d_ready, b_mem_enable, b_mem_wr;
    logic [15:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_data_in, b_mem_data_out;
    logic        b_stall_fetch, b_stall_mem;

    logic        pl_we;
    logic [15:0] pl_addr;
    logic [15:0] pl_data;
    logic [15:0] mem_a [65536];
    logic [15:0] mem_b [65536];

    int errors;
    int checks;

    mem_port_arbiter #(.LATENCY(2), .FAIR_LIMIT(4)) u_a (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(a_i_ready), .i_rdata(a_i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(a_d_ready), .d_rdata(a_d_rdata),
        .mem_enable(a_mem_enable), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
        .mem_data_in(a_mem_data_in), .mem_data_out(a_mem_data_out),
        .stall_fetch(a_stall_fetch), .stall_mem(a_stall_mem)
    );

    mem_port_arbiter #(.LATENCY(1), .FAIR_LIMIT(2)) u_b (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(b_i_ready), .i_rdata(b_i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(b_d_ready), .d_rdata(b_d_rdata),
        .mem_enable(b_mem_enable), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
        .mem_data_in(b_mem_data_in), .mem_data_out(b_mem_data_out),
        .stall_fetch(b_stall_fetch), .stall_mem(b_stall_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we) begin
            mem_a[pl_addr] <= pl_data;
            mem_b[pl_addr] <= pl_data;
        end else begin
            if (a_mem_enable && a_mem_wr) mem_a[a_mem_addr] <= a_mem_data_in;
            if (b_mem_enable && b_mem_wr) mem_b[b_mem_addr] <= b_mem_data_in;
        end
    end

    assign a_mem_data_out = mem_a[a_mem_addr];
    assign b_mem_data_out = mem_b[b_mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic preload(input logic [15:0] addr, input logic [15:0] data);
        pl_addr = addr;
        pl_data = data;
        pl_we   = 1'b1;
        tick();
        pl_we   = 1'b0;
    endtask

    task automatic test_reset();
        logic [67:0] got;
        rst = 1'b0;
        #2;
        got = {a_i_ready, a_d_ready, a_mem_enable, a_mem_wr,
               a_mem_addr, a_mem_data_in, a_i_rdata, a_d_rdata};
        checks++;
        if (got !== 68'h0) begin
            errors++;
            $display("FAIL reset_a got=%h exp=0", got);
        end
        got = {b_i_ready, b_d_ready, b_mem_enable, b_mem_wr,
               b_mem_addr, b_mem_data_in, b_i_rdata, b_d_rdata};
        checks++;
        if (got !== 68'h0) begin
            errors++;
            $display("FAIL reset_b got=%h exp=0", got);
        end
        checks++;
        if ({a_stall_fetch, a_stall_mem} !== 2'b00) begin
            errors++;
            $display("FAIL reset_stall got=%b exp=00", {a_stall_fetch, a_stall_mem});
        end
    endtask

    task automatic test_i_read();
        logic [2:0] got, exp;
        do_reset();
        i_addr = 16'h0010;
        i_req  = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            got = {a_mem_enable, a_i_ready, a_stall_fetch};
            exp = {(c == 1 || c == 2), (c == 3), (c <= 2)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL i_read_ctl c=%0d got=%b exp=%b", c, got, exp);
            end
            if (c == 1) begin
                checks++;
                if ({a_mem_addr, a_mem_wr} !== {16'h0010, 1'b0}) begin
                    errors++;
                    $display("FAIL i_read_addr got=%h/%b exp=0010/0", a_mem_addr, a_mem_wr);
                end
            end
            if (c == 3) begin
                checks++;
                if (a_i_rdata !== 16'hBEEF) begin
                    errors++;
                    $display("FAIL i_read_data got=%h exp=beef", a_i_rdata);
                end
            end
            tick();
            if (c == 3) i_req = 1'b0;
        end
    endtask

    task automatic test_write_read();
        logic [2:0] got, exp;
        do_reset();
        d_wr    = 1'b1;
        d_addr  = 16'h0040;
        d_wdata = 16'h1234;
        d_req   = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            got = {b_mem_enable, b_mem_wr, b_d_ready};
            exp = {(c == 1), (c == 1), (c == 2)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL write_ctl c=%0d got=%b exp=%b", c, got, exp);
            end
            if (c == 1) begin
                checks++;
                if ({b_mem_addr, b_mem_data_in} !== {16'h0040, 16'h1234}) begin
                    errors++;
                    $display("FAIL write_bus got=%h/%h exp=0040/1234", b_mem_addr, b_mem_data_in);
                end
            end
            if (c == 2) begin
                checks++;
                if (b_d_rdata !== 16'h0000) begin
                    errors++;
                    $display("FAIL write_rdata_held got=%h exp=0000", b_d_rdata);
                end
            end
            tick();
            if (c == 2) d_req = 1'b0;
        end
        d_wr  = 1'b0;
        d_req = 1'b1;
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            got = {b_mem_enable, b_mem_wr, b_d_ready};
            exp = {(c == 1), 1'b0, (c == 2)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL read_ctl c=%0d got=%b exp=%b", c, got, exp);
            end
            if (c == 2) begin
                checks++;
                if (b_d_rdata !== 16'h1234) begin
                    errors++;
                    $display("FAIL read_data got=%h exp=1234", b_d_rdata);
                end
            end
            tick();
            if (c == 2) d_req = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] got, exp;
        do_reset();
        d_wr   = 1'b0;
        d_addr = 16'h0040;
        i_addr = 16'h0020;
        d_req  = 1'b1;
        i_req  = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            got = {b_d_ready, b_i_ready, b_stall_fetch};
            exp = {(c == 2), (c == 5), (c <= 4)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL simul_ctl c=%0d got=%b exp=%b", c, got, exp);
            end
            if (c == 1 || c == 4) begin
                checks++;
                if (b_mem_addr !== ((c == 1) ? 16'h0040 : 16'h0020)) begin
                    errors++;
                    $display("FAIL simul_addr c=%0d got=%h exp=%h", c, b_mem_addr,
                             (c == 1) ? 16'h0040 : 16'h0020);
                end
            end
            if (c == 5) begin
                checks++;
                if ({b_i_rdata, b_d_rdata} !== {16'h5A5A, 16'h1234}) begin
                    errors++;
                    $display("FAIL simul_data got=%h/%h exp=5a5a/1234", b_i_rdata, b_d_rdata);
                end
            end
            tick();
            if (c == 2) d_req = 1'b0;
            if (c == 5) i_req = 1'b0;
        end
    endtask

    task automatic test_starvation();
        byte   seq [6];
        int    n;
        string exp;
`ifdef MEM_PORT_ARBITER_FAIR_EN
        exp = "DDIDDI";
`else
        exp = "DDDDDD";
`endif
        do_reset();
        n      = 0;
        d_wr   = 1'b0;
        d_addr = 16'h0040;
        i_addr = 16'h0020;
        d_req  = 1'b1;
        i_req  = 1'b1;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (b_d_ready) begin
                seq[n] = "D";
                n++;
            end else if (b_i_ready) begin
                seq[n] = "I";
                n++;
            end
            tick();
        end
        d_req = 1'b0;
        i_req = 1'b0;
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL starve_timeout got=%0d grants exp=6", n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (seq[k] !== exp[k]) begin
                errors++;
                $display("FAIL starve_seq k=%0d got=%c exp=%c", k, seq[k], exp[k]);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_addr_hold();
        do_reset();
        d_wr   = 1'b0;
        d_addr = 16'h0040;
        d_req  = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                checks++;
                if ({a_mem_addr, a_mem_enable, a_d_ready} !==
                    {16'h0040, (c <= 2), (c == 3)}) begin
                    errors++;
                    $display("FAIL addr_hold c=%0d got=%h/%b/%b", c,
                             a_mem_addr, a_mem_enable, a_d_ready);
                end
            end
            tick();
            if (c == 0) d_addr = 16'h0080;
            if (c == 3) d_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [67:0] got;
        do_reset();
        d_wr    = 1'b1;
        d_addr  = 16'h0050;
        d_wdata = 16'hA5A5;
        d_req   = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({a_mem_enable, a_mem_wr} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_pre got=%b exp=11", {a_mem_enable, a_mem_wr});
        end
        #1;
        rst = 1'b0;
        #1;
        got = {a_i_ready, a_d_ready, a_mem_enable, a_mem_wr,
               a_mem_addr, a_mem_data_in, a_i_rdata, a_d_rdata};
        checks++;
        if (got !== 68'h0) begin
            errors++;
            $display("FAIL rst_mid_clear got=%h exp=0", got);
        end
        d_req = 1'b0;
        d_wr  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 2) rst = 1'b1;
            @(negedge clk);
            checks++;
            if ({a_mem_enable, a_d_ready, a_i_ready} !== 3'b000) begin
                errors++;
                $display("FAIL rst_mid_after c=%0d got=%b exp=000", c,
                         {a_mem_enable, a_d_ready, a_i_ready});
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        i_req   = 1'b0;
        i_addr  = 16'h0000;
        d_req   = 1'b0;
        d_wr    = 1'b0;
        d_addr  = 16'h0000;
        d_wdata = 16'h0000;
        pl_we   = 1'b0;
        pl_addr = 16'h0000;
        pl_data = 16'h0000;
        test_reset();
        preload(16'h0010, 16'hBEEF);
        preload(16'h0020, 16'h5A5A);
        test_i_read();
        test_write_read();
        test_simultaneous();
        test_starvation();
        test_addr_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
